digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder.sv | 122 ++++++++++++
 tb/tb_digit_serial_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial add/subtract, LSB digit first, START/BUSY/DONE handshake
// Optional LC-3 N/Z/P condition-code outputs when ADDER_NZP_EN is defined.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CYI,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CYO,
  output logic             OVF
`ifdef ADDER_NZP_EN
  ,
  output logic             N,
  output logic             Z,
  output logic             P
`endif
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             ovf_next;

  always_comb begin
    dsum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  end

  // a_sr doubles as the result shift register: each consumed A digit is
  // replaced at the top by its sum digit, so after the last digit it holds SUM.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign a_next = dsum[DIGIT-1:0];
      assign b_next = b_sr;
    end else begin : g_multi
      assign a_next = {dsum[DIGIT-1:0], a_sr[WIDTH-1:DIGIT]};
      assign b_next = {{DIGIT{1'b0}}, b_sr[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign ovf_next = (a_msb == b_msb) && (a_next[WIDTH-1] != a_msb);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      SUM   <= '0;
      CYO   <= 1'b0;
      OVF   <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`ifdef ADDER_NZP_EN
      N     <= 1'b0;
      Z     <= 1'b0;
      P     <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_sr  <= A;
            b_sr  <= SUB ? ~B : B;
            carry <= SUB ? 1'b1 : CYI;
            a_msb <= A[WIDTH-1];
            b_msb <= SUB ? ~B[WIDTH-1] : B[WIDTH-1];
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_next;
          b_sr  <= b_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_DIGIT) begin
            SUM   <= a_next;
            CYO   <= dsum[DIGIT];
            OVF   <= ovf_next;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
`ifdef ADDER_NZP_EN
            N     <= a_next[WIDTH-1];
            Z     <= (a_next == '0);
            P     <= !a_next[WIDTH-1] && (a_next != '0);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed self-checking bench for digit_serial_adder
// Checks N/Z/P outputs as well when ADDER_NZP_EN is defined.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start4 = 1'b0, start16 = 1'b0, start1 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cyi = 1'b0, sub = 1'b0;

  logic        busy4, done4, cyo4, ovf4;
  logic [15:0] sum4;
  logic        busy16, done16, cyo16, ovf16;
  logic [15:0] sum16;
  logic        busy1, done1, cyo1, ovf1;
  logic [15:0] sum1;
`ifdef ADDER_NZP_EN
  logic n4, z4, p4, n16, z16, p16, n1, z1, p1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .A(a), .B(b), .CYI(cyi), .SUB(sub),
    .BUSY(busy4), .DONE(done4), .SUM(sum4), .CYO(cyo4), .OVF(ovf4)
`ifdef ADDER_NZP_EN
    , .N(n4), .Z(z4), .P(p4)
`endif
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .CLK(clk), .RST(rst), .START(start16), .A(a), .B(b), .CYI(cyi), .SUB(sub),
    .BUSY(busy16), .DONE(done16), .SUM(sum16), .CYO(cyo16), .OVF(ovf16)
`ifdef ADDER_NZP_EN
    , .N(n16), .Z(z16), .P(p16)
`endif
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A(a), .B(b), .CYI(cyi), .SUB(sub),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .CYO(cyo1), .OVF(ovf1)
`ifdef ADDER_NZP_EN
    , .N(n1), .Z(z1), .P(p1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      16:      return busy16;
      1:       return busy1;
      default: return busy4;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      16:      return done16;
      1:       return done1;
      default: return done4;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int sel);
    case (sel)
      16:      return sum16;
      1:       return sum1;
      default: return sum4;
    endcase
  endfunction

  function automatic logic [1:0] get_cyo_ovf(input int sel);
    case (sel)
      16:      return {cyo16, ovf16};
      1:       return {cyo1, ovf1};
      default: return {cyo4, ovf4};
    endcase
  endfunction

  // Run one operation on the selected instance; nzp is {N,Z,P}, checked on dut4 only.
  task automatic run_op(input string tag, input int sel, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcyi, input logic tsub, input int exp_lat,
                        input logic [15:0] exp_sum, input logic exp_cyo, input logic exp_ovf,
                        input logic [2:0] exp_nzp);
    int lat;
    a = ta; b = tb; cyi = tcyi; sub = tsub;
    case (sel)
      16:      start16 = 1'b1;
      1:       start1  = 1'b1;
      default: start4  = 1'b1;
    endcase
    step();
    start4 = 1'b0; start16 = 1'b0; start1 = 1'b0;
    chk({tag, "_busy_after_start"}, get_busy(sel), 1'b1);
    lat = 0;
    while (lat < 40 && !get_done(sel)) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_at_done"}, get_busy(sel), 1'b0);
    chk({tag, "_sum"}, get_sum(sel), exp_sum);
    chk({tag, "_cyo_ovf"}, get_cyo_ovf(sel), {exp_cyo, exp_ovf});
`ifdef ADDER_NZP_EN
    if (sel == 4) chk({tag, "_nzp"}, {n4, z4, p4}, exp_nzp);
`else
    if (exp_nzp == 3'b111) chk({tag, "_nzp_arg"}, exp_nzp, 3'b000);
`endif
    step();
    chk({tag, "_done_clears"}, get_done(sel), 1'b0);
    chk({tag, "_sum_held"}, get_sum(sel), exp_sum);
  endtask

  initial begin
    logic exp_d;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", busy4, 1'b0);
    chk("reset_done", done4, 1'b0);
    chk("reset_sum", sum4, 16'h0000);
    chk("reset_cyo_ovf", {cyo4, ovf4}, 2'b00);
`ifdef ADDER_NZP_EN
    chk("reset_nzp", {n4, z4, p4}, 3'b000);
`endif

    run_op("add_ovf",   4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 16'h8000, 1'b0, 1'b1, 3'b100);
    run_op("sub_neg",   4, 16'h0005, 16'h0007, 1'b0, 1'b1, 4, 16'hFFFE, 1'b0, 1'b0, 3'b100);
    run_op("sub_zero",  4, 16'h0007, 16'h0007, 1'b0, 1'b1, 4, 16'h0000, 1'b1, 1'b0, 3'b010);
    run_op("add_cyi",   4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 4, 16'h0000, 1'b1, 1'b0, 3'b010);
    run_op("sub_igcyi", 4, 16'h0003, 16'h0001, 1'b1, 1'b1, 4, 16'h0002, 1'b1, 1'b0, 3'b001);

    // START held high with operands changing every cycle: only edges 0 and 5 accept.
    a = 16'h0100; b = 16'h0001; cyi = 1'b0; sub = 1'b0;
    start4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      exp_d = (k == 4) || (k == 9);
      chk($sformatf("stream_done_%0d", k), done4, exp_d);
      chk($sformatf("stream_busy_%0d", k), busy4, !exp_d);
      if (k == 4) chk("stream_sum_first", sum4, 16'h0101);
      if (k == 6) chk("stream_sum_held", sum4, 16'h0101);
      if (k == 9) chk("stream_sum_second", sum4, 16'h0606);
      a = 16'(16'h0100 * (k + 2));
      b = 16'(k + 2);
    end
    start4 = 1'b0;
    step();
    chk("stream_done_clears", done4, 1'b0);

    // Reset during digit 2 of 4 aborts with no DONE.
    a = 16'h1111; b = 16'h2222;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    chk("abort_sum", sum4, 16'h0000);
    chk("abort_cyo_ovf", {cyo4, ovf4}, 2'b00);
`ifdef ADDER_NZP_EN
    chk("abort_nzp", {n4, z4, p4}, 3'b000);
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("abort_no_done_%0d", k), done4, 1'b0);
    end
    run_op("after_abort", 4, 16'h1234, 16'h4321, 1'b0, 1'b0, 4, 16'h5555, 1'b0, 1'b0, 3'b001);

    run_op("digit16", 16, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 16'h5555, 1'b0, 1'b0, 3'b001);
    run_op("digit1",  1,  16'h1234, 16'h4321, 1'b0, 1'b0, 16, 16'h5555, 1'b0, 1'b0, 3'b001);
    run_op("digit1_sub", 1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16, 16'h7FFF, 1'b1, 1'b1, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
